// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter/sequencer sharing one single-port memory between fetch (I) and load/store (D).
// Optional grant statistics counters are enabled by defining MEM_ARB_STATS_EN.
module mem_port_arbiter #(
    parameter int AW    = 10,
    parameter int DW    = 32,
    parameter int CNT_W = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic          i_ack,
    output logic [DW-1:0] i_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_ack,
    output logic [DW-1:0] d_rdata,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy
`ifdef MEM_ARB_STATS_EN
    ,
    output logic [CNT_W-1:0] i_grant_cnt,
    output logic [CNT_W-1:0] d_grant_cnt
`endif
);

    typedef enum logic [1:0] {IDLE, ACCESS, ACK} state_t;
    typedef enum logic [1:0] {OWN_NONE, OWN_I, OWN_D} owner_t;

    state_t state, state_next;
    owner_t owner, last_owner, grant;
    logic   lat_we;

    // Arbitration: on a tie the port that did not win last time gets the grant.
    always_comb begin
        state_next = state;
        grant      = OWN_NONE;
        case (state)
            IDLE: begin
                if (i_req && d_req) begin
                    grant = (last_owner == OWN_I) ? OWN_D : OWN_I;
                end else if (i_req) begin
                    grant = OWN_I;
                end else if (d_req) begin
                    grant = OWN_D;
                end
                if (grant != OWN_NONE) begin
                    state_next = ACCESS;
                end
            end
            ACCESS:  state_next = ACK;
            ACK:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            owner      <= OWN_NONE;
            last_owner <= OWN_D;
            lat_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            i_rdata    <= '0;
            d_rdata    <= '0;
        end else begin
            state <= state_next;
            if (grant == OWN_I) begin
                owner    <= OWN_I;
                mem_addr <= i_addr;
                lat_we   <= 1'b0;
            end else if (grant == OWN_D) begin
                owner     <= OWN_D;
                mem_addr  <= d_addr;
                mem_wdata <= d_wdata;
                lat_we    <= d_we;
            end
            // Same edge as the memory write, so a store captures the old contents.
            if (state == ACCESS) begin
                if (owner == OWN_I) begin
                    i_rdata <= mem_rdata;
                end else if (owner == OWN_D) begin
                    d_rdata <= mem_rdata;
                end
                last_owner <= owner;
            end
        end
    end

    // Decoded from state so an asynchronous reset kills a pending write at once.
    assign mem_we = (state == ACCESS) && lat_we;
    assign i_ack  = (state == ACK) && (owner == OWN_I);
    assign d_ack  = (state == ACK) && (owner == OWN_D);
    assign busy   = (state != IDLE);

`ifdef MEM_ARB_STATS_EN
    // Grant counters stick at all-ones instead of wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i_grant_cnt <= '0;
            d_grant_cnt <= '0;
        end else begin
            if (i_ack && (i_grant_cnt != {CNT_W{1'b1}})) begin
                i_grant_cnt <= i_grant_cnt + 1'b1;
            end
            if (d_ack && (d_grant_cnt != {CNT_W{1'b1}})) begin
                d_grant_cnt <= d_grant_cnt + 1'b1;
            end
        end
    end
`else
    logic [CNT_W-1:0] stats_unused;
    assign stats_unused = '0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter with a behavioural 1024x32 memory.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_req;
    logic [9:0]  i_addr;
    logic        i_ack;
    logic [31:0] i_rdata;
    logic        d_req;
    logic        d_we;
    logic [9:0]  d_addr;
    logic [31:0] d_wdata;
    logic        d_ack;
    logic [31:0] d_rdata;
    logic        mem_we;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        busy;
`ifdef MEM_ARB_STATS_EN
    logic [15:0] i_grant_cnt;
    logic [15:0] d_grant_cnt;
`endif

    logic [31:0] mem [0:1023];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
    end
    assign mem_rdata = mem[mem_addr];

    mem_port_arbiter #(.AW(10), .DW(32), .CNT_W(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_req     (i_req),
        .i_addr    (i_addr),
        .i_ack     (i_ack),
        .i_rdata   (i_rdata),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_ack     (d_ack),
        .d_rdata   (d_rdata),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .busy      (busy)
`ifdef MEM_ARB_STATS_EN
        ,
        .i_grant_cnt (i_grant_cnt),
        .d_grant_cnt (d_grant_cnt)
`endif
    );

    // Issues one D request from a negedge in IDLE and returns after the following IDLE negedge.
    task automatic d_access(input logic we, input logic [9:0] addr, input logic [31:0] wdata,
                            output logic [31:0] rdata, output int lat, output int we_cycles,
                            output logic got_ack);
        d_we = we; d_addr = addr; d_wdata = wdata; d_req = 1'b1;
        lat = 0; we_cycles = 0; got_ack = 1'b0; rdata = '0;
        for (int k = 0; k < 10 && !got_ack; k++) begin
            @(negedge clk);
            lat++;
            if (mem_we) we_cycles++;
            if (d_ack) begin
                got_ack = 1'b1;
                rdata = d_rdata;
                d_req = 1'b0;
            end
        end
        d_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset;
        rst_n = 1'b0; i_req = 1'b0; i_addr = '0;
        d_req = 1'b1; d_we = 1'b1; d_addr = 10'h003; d_wdata = 32'h1234_5678;
        repeat (2) @(negedge clk);
        checks++; if (mem_we !== 1'b0) begin errors++; $display("[TB] FAIL reset_mem_we: got %b want 0", mem_we); end
        checks++; if (i_ack !== 1'b0) begin errors++; $display("[TB] FAIL reset_i_ack: got %b want 0", i_ack); end
        checks++; if (d_ack !== 1'b0) begin errors++; $display("[TB] FAIL reset_d_ack: got %b want 0", d_ack); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b want 0", busy); end
        checks++; if (mem_addr !== 10'h000) begin errors++; $display("[TB] FAIL reset_mem_addr: got %h want 000", mem_addr); end
        checks++; if (d_rdata !== 32'h0) begin errors++; $display("[TB] FAIL reset_d_rdata: got %h want 0", d_rdata); end
        checks++; if (i_rdata !== 32'h0) begin errors++; $display("[TB] FAIL reset_i_rdata: got %h want 0", i_rdata); end
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL first_grant_busy: got %b want 1", busy); end
        checks++; if (mem_we !== 1'b1) begin errors++; $display("[TB] FAIL first_grant_we: got %b want 1", mem_we); end
        checks++; if (mem_addr !== 10'h003) begin errors++; $display("[TB] FAIL first_grant_addr: got %h want 003", mem_addr); end
        @(negedge clk);
        checks++; if (d_ack !== 1'b1) begin errors++; $display("[TB] FAIL first_grant_ack: got %b want 1", d_ack); end
        d_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_store_load;
        logic [31:0] rd;
        int lat, wec;
        logic ok;
        d_access(1'b1, 10'h005, 32'hDEAD_BEEF, rd, lat, wec, ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("[TB] FAIL store_ack_seen: got %b want 1", ok); end
        checks++; if (lat != 2) begin errors++; $display("[TB] FAIL store_latency: got %0d want 2", lat); end
        checks++; if (wec != 1) begin errors++; $display("[TB] FAIL store_we_cycles: got %0d want 1", wec); end
        d_access(1'b0, 10'h005, 32'h0, rd, lat, wec, ok);
        checks++; if (rd !== 32'hDEAD_BEEF) begin errors++; $display("[TB] FAIL load_data: got %h want deadbeef", rd); end
        checks++; if (wec != 0) begin errors++; $display("[TB] FAIL load_we_cycles: got %0d want 0", wec); end
    endtask

    task automatic test_read_before_write;
        logic [31:0] rd;
        int lat, wec;
        logic ok;
        d_access(1'b1, 10'h010, 32'h1111_1111, rd, lat, wec, ok);
        d_access(1'b1, 10'h010, 32'h2222_2222, rd, lat, wec, ok);
        checks++; if (rd !== 32'h1111_1111) begin errors++; $display("[TB] FAIL rbw_old_data: got %h want 11111111", rd); end
        d_access(1'b0, 10'h010, 32'h0, rd, lat, wec, ok);
        checks++; if (rd !== 32'h2222_2222) begin errors++; $display("[TB] FAIL rbw_new_data: got %h want 22222222", rd); end
    endtask

    task automatic test_contention;
        logic [31:0] rd;
        int lat, wec, cyc, last_cyc, n;
        logic ok, prev_we;
        d_access(1'b1, 10'h040, 32'hAAAA_0040, rd, lat, wec, ok);
        d_access(1'b1, 10'h080, 32'hBBBB_0080, rd, lat, wec, ok);
        rst_n = 1'b0;
        i_req = 1'b1; i_addr = 10'h040;
        d_req = 1'b1; d_we = 1'b1; d_addr = 10'h080; d_wdata = 32'h0000_0055;
        @(negedge clk);
        rst_n = 1'b1;
        cyc = 0; last_cyc = 0; n = 0; prev_we = 1'b0;
        while (cyc < 20 && n < 4) begin
            @(negedge clk);
            cyc++;
            if (i_ack || d_ack) begin
                checks++;
                if ((i_ack !== ((n % 2) == 0)) || (d_ack !== ((n % 2) == 1))) begin
                    errors++; $display("[TB] FAIL contention_order ack %0d: got i=%b d=%b want i=%b", n, i_ack, d_ack, (n % 2) == 0);
                end
                checks++;
                if (cyc - last_cyc != ((n == 0) ? 2 : 3)) begin
                    errors++; $display("[TB] FAIL contention_gap ack %0d: got %0d cycles want %0d", n, cyc - last_cyc, (n == 0) ? 2 : 3);
                end
                if (i_ack) begin
                    checks++; if (prev_we !== 1'b0) begin errors++; $display("[TB] FAIL contention_i_we ack %0d: got %b want 0", n, prev_we); end
                    checks++; if (i_rdata !== 32'hAAAA_0040) begin errors++; $display("[TB] FAIL contention_i_rdata ack %0d: got %h want aaaa0040", n, i_rdata); end
                end else begin
                    checks++; if (prev_we !== 1'b1) begin errors++; $display("[TB] FAIL contention_d_we ack %0d: got %b want 1", n, prev_we); end
                    checks++;
                    if (d_rdata !== ((n == 1) ? 32'hBBBB_0080 : 32'h0000_0055)) begin
                        errors++; $display("[TB] FAIL contention_d_rdata ack %0d: got %h want %h", n, d_rdata, (n == 1) ? 32'hBBBB_0080 : 32'h0000_0055);
                    end
                end
                last_cyc = cyc;
                n++;
            end
            prev_we = mem_we;
        end
        i_req = 1'b0; d_req = 1'b0;
        checks++; if (n != 4) begin errors++; $display("[TB] FAIL contention_timeout: got %0d acks want 4", n); end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_back_to_back;
        logic [31:0] rd;
        int lat, wec, cyc, n;
        logic ok;
        logic [31:0] exp_data [0:2];
        exp_data[0] = 32'h0000_1001;
        exp_data[1] = 32'h0000_2002;
        exp_data[2] = 32'h0000_3003;
        d_access(1'b1, 10'h001, exp_data[0], rd, lat, wec, ok);
        d_access(1'b1, 10'h002, exp_data[1], rd, lat, wec, ok);
        d_access(1'b1, 10'h003, exp_data[2], rd, lat, wec, ok);
        i_addr = 10'h001; i_req = 1'b1;
        cyc = 0; n = 0;
        while (cyc < 9) begin
            @(negedge clk);
            cyc++;
            checks++;
            if (busy !== ((cyc % 3) != 0)) begin
                errors++; $display("[TB] FAIL b2b_busy cycle %0d: got %b want %b", cyc, busy, (cyc % 3) != 0);
            end
            if (i_ack) begin
                if (n < 3) begin
                    checks++; if (i_rdata !== exp_data[n]) begin errors++; $display("[TB] FAIL b2b_rdata ack %0d: got %h want %h", n, i_rdata, exp_data[n]); end
                    checks++; if (cyc != 2 + 3 * n) begin errors++; $display("[TB] FAIL b2b_timing ack %0d: got cycle %0d want %0d", n, cyc, 2 + 3 * n); end
                end
                n++;
                if (n >= 3) i_req = 1'b0;
                else i_addr = 10'(n + 1);
            end
        end
        i_req = 1'b0;
        checks++; if (n != 3) begin errors++; $display("[TB] FAIL b2b_ack_count: got %0d want 3", n); end
        @(negedge clk);
    endtask

    task automatic test_abort;
        logic [31:0] rd;
        int lat, wec;
        logic ok;
        d_access(1'b1, 10'h020, 32'h0, rd, lat, wec, ok);
        d_we = 1'b1; d_addr = 10'h020; d_wdata = 32'hCAFE_F00D; d_req = 1'b1;
        @(negedge clk);
        checks++; if (mem_we !== 1'b1) begin errors++; $display("[TB] FAIL abort_access_we: got %b want 1", mem_we); end
        rst_n = 1'b0;
        #1;
        checks++; if (mem_we !== 1'b0) begin errors++; $display("[TB] FAIL abort_async_we: got %b want 0", mem_we); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL abort_busy: got %b want 0", busy); end
        d_req = 1'b0;
        repeat (2) begin
            @(negedge clk);
            checks++; if (d_ack !== 1'b0) begin errors++; $display("[TB] FAIL abort_no_ack: got %b want 0", d_ack); end
        end
        checks++; if (mem[10'h020] !== 32'h0) begin errors++; $display("[TB] FAIL abort_mem: got %h want 0", mem[10'h020]); end
        rst_n = 1'b1;
        @(negedge clk);
`ifdef MEM_ARB_STATS_EN
        checks++; if (i_grant_cnt !== 16'h0) begin errors++; $display("[TB] FAIL stats_i_reset: got %h want 0", i_grant_cnt); end
        checks++; if (d_grant_cnt !== 16'h0) begin errors++; $display("[TB] FAIL stats_d_reset: got %h want 0", d_grant_cnt); end
`endif
        d_access(1'b0, 10'h020, 32'h0, rd, lat, wec, ok);
        checks++; if (rd !== 32'h0) begin errors++; $display("[TB] FAIL abort_readback: got %h want 0", rd); end
`ifdef MEM_ARB_STATS_EN
        checks++; if (d_grant_cnt !== 16'h1) begin errors++; $display("[TB] FAIL stats_d_count: got %h want 1", d_grant_cnt); end
        checks++; if (i_grant_cnt !== 16'h0) begin errors++; $display("[TB] FAIL stats_i_count: got %h want 0", i_grant_cnt); end
`endif
    endtask

    initial begin
        test_reset();
        test_store_load();
        test_read_before_write();
        test_contention();
        test_back_to_back();
        test_abort();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Two-requester arbiter and sequencer for the shared single-port 1024x32 instruction/data memory: instruction-fetch port (I) and load/store port (D).
- Sits between the core's fetch and load/store stages and the memory's clk/regWE/Addr/DataIn/DataOut interface.
- Memory write is synchronous and read is combinational.
- Serialises accesses with round-robin fairness, latches request fields, drives the memory for exactly one cycle per access, and returns registered read data with a one-cycle ack pulse.

Parameters:
- AW, 10, memory address width.
- DW, 32, data width.
- CNT_W, 16, width of grant statistics counters (used only with the optional feature).

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- i_req  input  1  fetch request; held high until i_ack
- i_addr  input  AW  fetch word address
- i_ack  output  1  one-cycle pulse: fetch complete, i_rdata valid
- i_rdata  output  DW  fetch read data, registered
- d_req  input  1  load/store request; held high until d_ack
- d_we  input  1  1 = store, 0 = load
- d_addr  input  AW  load/store word address
- d_wdata  input  DW  store data
- d_ack  output  1  one-cycle pulse: load/store complete, d_rdata valid
- d_rdata  output  DW  load data, registered
- mem_we  output  1  to memory regWE
- mem_addr  output  AW  to memory Addr
- mem_wdata  output  DW  to memory DataIn
- mem_rdata  input  DW  from memory DataOut
- busy  output  1  high in any state other than IDLE

Behaviour:
- Clock and reset: one clock (clk). Reset rst_n is asynchronous, active-low. All state is reset asynchronously.
- Reset values:
  - state = IDLE; i_ack = d_ack = 0; i_rdata = d_rdata = 0.
  - mem_addr = 0; mem_wdata = 0; owner = none; last_owner = D, so I wins the first tie.
  - mem_we = 0 and busy = 0.
- FSM states: IDLE, ACCESS, ACK.
- IDLE:
  - Neither req high: stay in IDLE.
  - Exactly one req high: grant that port.
  - Both req high: grant the port that is not last_owner.
  - On grant: latch owner, address, we (forced 0 for I) and wdata into registers; go to ACCESS.
- ACCESS (exactly 1 cycle):
  - mem_addr and mem_wdata come from the latched registers.
  - mem_we = latched we, decoded combinationally from state and registers; it is never high outside ACCESS.
  - At the closing edge: capture mem_rdata into the owner's rdata register; update last_owner = owner; go to ACK.
- ACK (exactly 1 cycle):
  - Owner's ack = 1; the other ack = 0.
  - All req inputs are ignored; always go to IDLE.
- Latency: request seen at edge of cycle 0 → ACCESS in cycle 1 → ack in cycle 2. Throughput is one access per 3 cycles.
- Requester rule: fields must stay stable until ack. If req is still high in the cycle after ack, it is a new request.
- Store read-back: d_rdata on a store returns the pre-write memory contents (read-before-write), because the memory write and the rdata capture occur on the same edge.
- The losing requester keeps req high. It is guaranteed service on the next arbitration, so wait is bounded at 3 cycles after the current ack.
- Non-owner rdata registers hold their previous value.
- mem_addr and mem_wdata hold their last latched values while IDLE.
- Reset mid-operation: rst_n low in ACCESS drops mem_we to 0 asynchronously, before the edge, so no write occurs. No ack is issued for an aborted request; the requester must re-request after reset.
- Widths: addresses pass through unmodified with no wrap logic. Out-of-range addresses are not possible at AW = 10.

Optional Feature:
- Macro: MEM_ARB_STATS_EN.
- With the macro defined, the block adds two outputs:
  - i_grant_cnt [CNT_W-1:0] and d_grant_cnt [CNT_W-1:0].
  - Each increments by 1 in the cycle its port's ack pulses.
  - Each saturates at all-ones (no wrap) and resets to 0 on rst_n.
- Without the macro, these ports and counters do not exist and all other behaviour is identical.

Test Plan:
1. Reset: assert rst_n=0 with d_req=1, d_we=1 → mem_we=0, i_ack=d_ack=0, busy=0, mem_addr=0. Release rst_n → the first grant happens on the next edge.
2. Single store then load: d_req with we=1, addr=0x005, wdata=0xDEADBEEF → mem_we high for exactly 1 cycle, d_ack 2 cycles after the request edge. Then a load from 0x005 → d_rdata=0xDEADBEEF with d_ack.
3. Read-before-write: mem[0x010]=0x11111111; store 0x22222222 to 0x010 → d_rdata=0x11111111 on d_ack. A following load → 0x22222222.
4. Contention: i_req and d_req both held high continuously from reset → acks alternate I, D, I, D. No port waits more than 3 cycles after the other port's ack. mem_we is never high during an I access.
5. Back-to-back: i_req held high across ack with a new address 0x001, 0x002, 0x003 → i_ack every 3 cycles with the matching i_rdata values and busy toggling as specified.
6. Abort: assert rst_n low during an ACCESS cycle of a store to 0x020 holding 0x0 → mem[0x020] is still 0x0 after reset and no d_ack occurs. With MEM_ARB_STATS_EN: counters read 0 after reset and saturate at 0xFFFF after forced overflow.
